// File: rtl/uart_report_pkg.sv
// uart_report_pkg: shared types and constants for the UART report scheduler and its decimal formatter.
package uart_report_pkg;

    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_MINUS  = 8'h2D;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_DIGIT0 = 8'd48;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first pending channel at or after rr_ptr.
module rr_arbiter #(
    parameter int N_CH = 4,
    localparam int IW = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] pend,
    input  logic [IW-1:0]   rr_ptr,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_idx
);

    logic [IW-1:0] idx;

    // Walk offsets downward so the closest pending channel to rr_ptr is the last one written.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = IW'((int'(rr_ptr) + i) % N_CH);
            if (pend[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/uart_report_scheduler.sv
// uart_report_scheduler: latches per-channel results and feeds them one at a time,
// round-robin, to a shared decimal-ASCII UART formatter.
module uart_report_scheduler
    import uart_report_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BUSY_TIMEOUT = 16,
    parameter int CNT_W        = 8,
    localparam int IW = $clog2(N_CH)
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [N_CH-1:0]          i_req,
    input  logic [N_CH*DATA_W-1:0]   i_data,
    output logic [N_CH-1:0]          o_ack,
    output logic [DATA_W-1:0]        o_fmt_data,
    output logic                     o_fmt_start,
    input  logic                     i_fmt_idle,
    output logic [IW-1:0]            o_grant_id,
    output logic                     o_busy,
    output logic [CNT_W-1:0]         o_ovf_cnt,
    output logic                     o_err
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    state_t              state, state_n;
    logic [N_CH-1:0]     pend;
    logic [DATA_W-1:0]   hold [N_CH];
    logic [IW-1:0]       rr_ptr;
    logic [TW-1:0]       to_cnt;
    logic                grant_valid;
    logic [IW-1:0]       grant_idx;
    logic                fire;
    logic                err_set;
    logic [N_CH-1:0]     grant_oh;
    logic [N_CH-1:0]     ovf_hit;
    logic [3:0]          ovf_pc;
    logic [CNT_W+3:0]    ovf_sum;
    logic [CNT_W-1:0]    ovf_next;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .pend       (pend),
        .rr_ptr     (rr_ptr),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    // Leaving IDLE requires an idle formatter, since the formatter survives our reset.
    always_comb begin
        state_n = state;
        fire    = 1'b0;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid && i_fmt_idle) begin
                    fire    = 1'b1;
                    state_n = START;
                end
            end
            START:     state_n = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!i_fmt_idle) begin
                    state_n = WAIT_DONE;
                end else if (to_cnt == TW'(BUSY_TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_DONE: state_n = i_fmt_idle ? GAP : WAIT_DONE;
            GAP:       state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // A request landing on the channel being granted refills it without counting an overwrite.
    always_comb begin
        grant_oh = fire ? (N_CH'(1) << grant_idx) : '0;
        ovf_hit  = i_req & pend & ~grant_oh;
        ovf_pc   = '0;
        for (int i = 0; i < N_CH; i++) ovf_pc = ovf_pc + 4'(ovf_hit[i]);
        ovf_sum  = {4'b0, o_ovf_cnt} + (CNT_W + 4)'(ovf_pc);
        ovf_next = (ovf_sum > {4'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : ovf_sum[CNT_W-1:0];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            pend        <= '0;
            rr_ptr      <= '0;
            to_cnt      <= '0;
            o_ack       <= '0;
            o_fmt_data  <= '0;
            o_fmt_start <= 1'b0;
            o_grant_id  <= '0;
            o_ovf_cnt   <= '0;
            o_err       <= 1'b0;
            for (int k = 0; k < N_CH; k++) hold[k] <= '0;
        end else begin
            state       <= state_n;
            pend        <= (pend & ~grant_oh) | i_req;
            to_cnt      <= (state == WAIT_BUSY) ? to_cnt + TW'(1) : '0;
            o_ack       <= grant_oh;
            o_fmt_start <= fire;
            o_ovf_cnt   <= ovf_next;
            o_err       <= o_err | err_set;
            if (fire) begin
                o_fmt_data <= hold[grant_idx];
                o_grant_id <= grant_idx;
                rr_ptr     <= (grant_idx == IW'(N_CH - 1)) ? '0 : grant_idx + IW'(1);
            end
            for (int k = 0; k < N_CH; k++)
                if (i_req[k]) hold[k] <= i_data[k*DATA_W +: DATA_W];
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_report_scheduler.sv
// tb_uart_report_scheduler: table-driven, directed and randomized checks against a scoreboard
// model of pending channels plus a stub decimal formatter that renders the UART text.
module tb_uart_report_scheduler;

    localparam int N = 4;
    localparam int W = 16;

    logic           Clk = 1'b0;
    logic           Rst = 1'b1;
    logic [N-1:0]   i_req = '0;
    logic [N*W-1:0] i_data = '0;
    logic           i_fmt_idle = 1'b1;
    logic [N-1:0]   o_ack;
    logic [W-1:0]   o_fmt_data;
    logic           o_fmt_start;
    logic [1:0]     o_grant_id;
    logic           o_busy;
    logic [7:0]     o_ovf_cnt;
    logic           o_err;

    always #5 Clk = ~Clk;

    uart_report_scheduler dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_req      (i_req),
        .i_data     (i_data),
        .o_ack      (o_ack),
        .o_fmt_data (o_fmt_data),
        .o_fmt_start(o_fmt_start),
        .i_fmt_idle (i_fmt_idle),
        .o_grant_id (o_grant_id),
        .o_busy     (o_busy),
        .o_ovf_cnt  (o_ovf_cnt),
        .o_err      (o_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (act.len() + exp.len() < 300)
                $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
            else
                $display("FAIL %s: got %0d chars, expected %0d chars", name, act.len(), exp.len());
        end
    endtask

    // Stub formatter: mode 0 goes busy for busy_len cycles after a start; mode 1 never leaves idle.
    int          fmt_mode = 0;
    int          busy_len = 8;
    int          fmt_cnt  = 0;
    logic [15:0] fmt_lat  = '0;
    bit          fmt_abort = 0;
    string       uart_log = "";

    always @(negedge Clk) begin
        if (fmt_cnt > 0) begin
            fmt_cnt--;
            if (fmt_cnt == 0) begin
                if (!fmt_abort) check("fmt_data_stable", o_fmt_data, fmt_lat);
                uart_log   = {uart_log, $sformatf("%0d\r", $signed(fmt_lat))};
                i_fmt_idle = 1'b1;
            end
        end else if (o_fmt_start && fmt_mode == 0) begin
            fmt_lat    = o_fmt_data;
            fmt_cnt    = busy_len;
            fmt_abort  = 0;
            i_fmt_idle = 1'b0;
        end
    end

    // Scoreboard: pending flags and latest values per channel, rotating search pointer.
    bit          mdl_pend [N];
    logic [15:0] mdl_hold [N];
    int          mdl_rr    = 0;
    int          mdl_ovf   = 0;
    int          start_cnt = 0;
    string       exp_log   = "";
    logic [N-1:0]   mon_rq;
    logic [N*W-1:0] mon_dt;
    logic           mon_idle;
    int             mon_k;

    always @(posedge Clk) begin
        mon_rq   = i_req;
        mon_dt   = i_data;
        mon_idle = i_fmt_idle;
        #1;
        if (Rst) begin
            for (int c = 0; c < N; c++) begin
                mdl_pend[c] = 0;
                mdl_hold[c] = '0;
            end
            mdl_rr  = 0;
            mdl_ovf = 0;
            if (fmt_cnt > 0) fmt_abort = 1;
            check("rst_start", o_fmt_start, 0);
            check("rst_ack", o_ack, 0);
            check("rst_data", o_fmt_data, 0);
            check("rst_grant_id", o_grant_id, 0);
            check("rst_busy", o_busy, 0);
            check("rst_ovf", o_ovf_cnt, 0);
            check("rst_err", o_err, 0);
        end else begin
            if (o_fmt_start) begin
                start_cnt++;
                mon_k = -1;
                for (int off = 0; off < N; off++)
                    if (mon_k < 0 && mdl_pend[(mdl_rr + off) % N]) mon_k = (mdl_rr + off) % N;
                if (mon_k < 0) begin
                    check("spurious_start", o_fmt_start, 0);
                end else begin
                    check("grant_id", o_grant_id, mon_k);
                    check("grant_data", o_fmt_data, mdl_hold[mon_k]);
                    check("grant_ack", o_ack, 32'(1) << mon_k);
                    check("start_while_fmt_busy", mon_idle, 1);
                    mdl_pend[mon_k] = 0;
                    mdl_rr  = (mon_k + 1) % N;
                    exp_log = {exp_log, $sformatf("%0d\r", $signed(mdl_hold[mon_k]))};
                end
            end else if (o_ack != '0) begin
                check("ack_without_start", o_ack, 0);
            end
            for (int c = 0; c < N; c++) begin
                if (mon_rq[c]) begin
                    if (mdl_pend[c]) mdl_ovf = (mdl_ovf < 255) ? mdl_ovf + 1 : 255;
                    mdl_pend[c] = 1;
                    mdl_hold[c] = mon_dt[c*W +: W];
                end
            end
            check("ovf_cnt", o_ovf_cnt, mdl_ovf);
        end
    end

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic pulse(input int ch, input logic [15:0] val);
        @(negedge Clk);
        i_req = N'(1) << ch;
        i_data[ch*W +: W] = val;
        @(negedge Clk);
        i_req = '0;
    endtask

    task automatic wait_quiet(input int budget);
        int  t = 0;
        bit  done = 0;
        bit  any;
        while (!done && t < budget) begin
            @(negedge Clk);
            t++;
            any = 0;
            for (int c = 0; c < N; c++) any |= mdl_pend[c];
            done = !o_busy && i_fmt_idle && fmt_cnt == 0 && !any;
        end
        if (!done) check("quiet_timeout", 0, 1);
    endtask

    typedef struct {
        int          ch;
        logic [15:0] val;
        string       txt;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat;
        int s0;
        vecs[0] = '{2, 16'hFF85, "-123\r"};
        vecs[1] = '{0, 16'h0000, "0\r"};
        vecs[2] = '{1, 16'h7FFF, "32767\r"};
        vecs[3] = '{3, 16'h8000, "-32768\r"};
        vecs[4] = '{2, 16'hFFFF, "-1\r"};
        vecs[5] = '{0, 16'd1000, "1000\r"};

        repeat (2) @(negedge Clk);
        Rst = 1'b0;

        // Single requests: latency, one-cycle start/ack, held data, rendered text.
        for (int v = 0; v < 6; v++) begin
            uart_log = "";
            @(negedge Clk);
            i_req = N'(1) << vecs[v].ch;
            i_data[vecs[v].ch*W +: W] = vecs[v].val;
            @(negedge Clk);
            i_req = '0;
            lat = 1;
            while (!o_fmt_start && lat < 10) begin
                @(negedge Clk);
                lat++;
            end
            check("latency", lat, 2);
            check("tbl_grant_id", o_grant_id, vecs[v].ch);
            check("tbl_data", o_fmt_data, vecs[v].val);
            check("tbl_ack", o_ack, 32'(1) << vecs[v].ch);
            @(negedge Clk);
            check("start_width", o_fmt_start, 0);
            check("ack_width", o_ack, 0);
            wait_quiet(200);
            check_str("tbl_text", uart_log, vecs[v].txt);
            check("tbl_hold_id", o_grant_id, vecs[v].ch);
            check("tbl_hold_data", o_fmt_data, vecs[v].val);
        end

        // All four at once from rr_ptr=0.
        do_reset();
        uart_log = "";
        @(negedge Clk);
        i_req  = '1;
        i_data = {16'd4, 16'd3, 16'd2, 16'd1};
        @(negedge Clk);
        i_req = '0;
        wait_quiet(500);
        check_str("all4_text", uart_log, "1\r2\r3\r4\r");
        check("all4_last_id", o_grant_id, 3);

        // Overwrite while channel 0 is being printed, then saturation.
        do_reset();
        uart_log = "";
        busy_len = 20;
        pulse(0, 16'd100);
        repeat (3) @(negedge Clk);
        pulse(1, 16'd10);
        pulse(1, 16'd20);
        wait_quiet(500);
        check_str("ovf_text", uart_log, "100\r20\r");
        check("ovf_one", o_ovf_cnt, 1);
        busy_len = 400;
        pulse(0, 16'd1);
        repeat (3) @(negedge Clk);
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            i_req = 4'b0010;
            i_data[W +: W] = 16'(i);
        end
        @(negedge Clk);
        i_req = '0;
        wait_quiet(2000);
        check("ovf_saturated", o_ovf_cnt, 255);
        busy_len = 8;

        // Formatter never leaves idle: timeout after 16 WAIT_BUSY cycles.
        do_reset();
        fmt_mode = 1;
        @(negedge Clk);
        i_req = 4'b0001;
        i_data[0 +: W] = 16'd55;
        @(negedge Clk);
        i_req = '0;
        @(negedge Clk);
        check("to_start", o_fmt_start, 1);
        repeat (16) @(negedge Clk);
        check("to_err_early", o_err, 0);
        check("to_busy_early", o_busy, 1);
        @(negedge Clk);
        check("to_err_set", o_err, 1);
        check("to_back_idle", o_busy, 0);
        fmt_mode = 0;
        uart_log = "";
        pulse(1, 16'd7);
        wait_quiet(200);
        check_str("to_next_served", uart_log, "7\r");
        check("to_err_sticky", o_err, 1);

        // Reset during WAIT_DONE with two channels pending.
        do_reset();
        busy_len = 40;
        uart_log = "";
        pulse(0, 16'd11);
        repeat (6) @(negedge Clk);
        @(negedge Clk);
        i_req = 4'b0110;
        i_data[W +: W]   = 16'd33;
        i_data[2*W +: W] = 16'd44;
        @(negedge Clk);
        i_req = '0;
        repeat (3) @(negedge Clk);
        check("mid_busy", o_busy, 1);
        check("mid_fmt_busy", i_fmt_idle, 0);
        Rst = 1'b1;
        @(negedge Clk);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_data", o_fmt_data, 0);
        Rst = 1'b0;
        s0 = start_cnt;
        lat = 0;
        while (!i_fmt_idle && lat < 100) begin
            @(negedge Clk);
            lat++;
        end
        check("no_grant_while_fmt_busy", start_cnt, s0);
        repeat (5) @(negedge Clk);
        check("pend_cleared", start_cnt, s0);
        busy_len = 8;
        pulse(3, 16'd77);
        wait_quiet(200);
        check_str("rst_text", uart_log, "11\r77\r");

        // New request on channel 3 at the very edge it is granted.
        do_reset();
        uart_log = "";
        @(negedge Clk);
        i_req = 4'b1000;
        i_data[3*W +: W] = 16'd9;
        @(negedge Clk);
        i_data[3*W +: W] = 16'd5;
        @(negedge Clk);
        i_req = '0;
        check("same_edge_start", o_fmt_start, 1);
        check("same_edge_data", o_fmt_data, 9);
        wait_quiet(200);
        check_str("same_edge_text", uart_log, "9\r5\r");
        check("same_edge_ovf", o_ovf_cnt, 0);

        // Random traffic; the formatter's text must equal the scoreboard's grant sequence.
        do_reset();
        uart_log = "";
        exp_log  = "";
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge Clk);
            busy_len = $urandom_range(2, 12);
            for (int c = 0; c < N; c++) begin
                i_req[c] = ($urandom_range(0, 7) == 0);
                i_data[c*W +: W] = 16'($urandom);
            end
        end
        @(negedge Clk);
        i_req = '0;
        wait_quiet(2000);
        check_str("random_log", uart_log, exp_log);
        check("random_err", o_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_report_scheduler.md
Name: uart_report_scheduler

Overview:
- Shares the single decimal-ASCII UART TX formatter (16-bit signed value in, start pulse, idle flag out) between N_CH independent result producers: classifier output, heartbeat counter, debug taps.
- Latches each producer's value into a per-channel holding register.
- Grants channels round-robin and drives exactly one formatter transaction at a time.
- Holds the formatter data input stable for the whole transaction, because the formatter re-reads the sign bit after its start cycle.

Parameters:
- N_CH, 4, number of requesting channels (2..8).
- DATA_W, 16, value width; must match the formatter input.
- BUSY_TIMEOUT, 16, cycles allowed in WAIT_BUSY for the formatter to leave idle.
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- i_req  in  N_CH  one-cycle request pulse per channel.
- i_data  in  N_CH*DATA_W  channel k value at bits [k*DATA_W +: DATA_W]; sampled when i_req[k]=1.
- o_ack  out  N_CH  one-cycle pulse when channel k's held value is granted.
- o_fmt_data  out  DATA_W  value to the formatter.
- o_fmt_start  out  1  one-cycle start pulse to the formatter.
- i_fmt_idle  in  1  formatter idle flag.
- o_grant_id  out  $clog2(N_CH)  channel currently or last granted.
- o_busy  out  1  high whenever state is not IDLE.
- o_ovf_cnt  out  CNT_W  saturating count of overwritten pending values.
- o_err  out  1  sticky timeout flag; cleared only by Rst.

Behaviour:
- Reset values: all outputs 0; pend[] = 0; hold[] = 0; rr_ptr = 0; state = IDLE.
- Reset mid-transaction aborts immediately: o_fmt_start drops and pending values are lost.
  - The formatter has no reset. The scheduler therefore never leaves IDLE while i_fmt_idle=0.
- Capture:
  - i_req[k]=1 at edge e sets pend[k] and loads hold[k] from i_data at e.
  - If pend[k] is already 1 and not being granted at e, the new value overwrites hold[k] and o_ovf_cnt increments, saturating at all-ones.
  - Simultaneous i_req[k] and grant of k at the same edge: the old value goes to the formatter; pend[k] stays 1 with the new value; no overflow count.
- Arbitration:
  - Round-robin, searching from rr_ptr upward with wrap.
  - On grant of k: rr_ptr <= k+1 mod N_CH.
  - Arbitration happens only in IDLE.
- FSM:
  - IDLE: if any pend and i_fmt_idle=1, then at the next edge:
    - o_fmt_data <= hold[k], o_grant_id <= k;
    - pend[k] cleared, o_ack[k]=1 for one cycle;
    - o_fmt_start <= 1; state -> START.
  - START: lasts exactly 1 cycle; o_fmt_start deasserts at the next edge; -> WAIT_BUSY; timeout counter = 0.
  - WAIT_BUSY:
    - i_fmt_idle=0 -> WAIT_DONE.
    - Otherwise increment the counter; at BUSY_TIMEOUT-1, set o_err=1 and go to IDLE. The value is dropped, not retried.
  - WAIT_DONE: i_fmt_idle=1 -> GAP.
  - GAP: 1 cycle -> IDLE. This lets the formatter's final carriage-return byte settle its internal start register.
- Timing and stability:
  - o_fmt_data is constant from the START edge until the next grant.
  - Latency from i_req pulse to o_fmt_start high: 2 cycles when idle.
  - Minimum spacing between two o_fmt_start pulses: 4 cycles plus formatter busy time.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Shared package uart_report_pkg:
  - state encoding localparams: IDLE=0, START=1, WAIT_BUSY=2, WAIT_DONE=3, GAP=4;
  - DATA_W default;
  - ASCII constants already used by the formatter ("-" 8'h2D, CR 8'h0D, digit offset 48).
- One sub-module: rr_arbiter.
  - Parameter N_CH. Inputs: pend vector, rr_ptr. Outputs: grant_valid, grant_idx.
  - Purely combinational, instantiated once.
- The formatter itself sits outside this block, in the same top level.

Test Plan:
- Single request: i_req[2] pulse with i_data ch2 = 16'hFF85 (-123).
  - o_fmt_start exactly 2 cycles later; o_fmt_data=16'hFF85 and o_grant_id=2 held until the formatter emits "-123\r".
  - o_ack[2] pulses once.
- All four channels pulse in the same cycle with values 1, 2, 3, 4; rr_ptr=0.
  - Grants in order 0,1,2,3; UART shows "1\r2\r3\r4\r".
  - Never two starts while i_fmt_idle=0.
- Channel 1 pulses 10 then 20 while channel 0's transaction is busy.
  - Only 20 is sent for channel 1; o_ovf_cnt=1.
  - With 300 overwrites, o_ovf_cnt saturates at 255.
- Stub formatter holds i_fmt_idle=1 after the start pulse.
  - o_err=1 after 16 WAIT_BUSY cycles; state returns to IDLE; the next request is still served.
- Assert Rst during WAIT_DONE with two channels pending.
  - All outputs 0, pend cleared.
  - After release, no grant occurs until i_fmt_idle=1; a new request is then served normally.
- i_req[3] pulse with value 5 at the exact edge channel 3 is granted with value 9.
  - 9 is sent first; pend[3] stays set; 5 is sent next; o_ovf_cnt unchanged.
